// File: rtl/sram_access_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and default widths for the SRAM access arbiter.
//   - state_e : access sequencer states
//   - grant_e : which requester was served most recently (round-robin memory)
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_WR_END = 3'd2,
        S_RD     = 3'd3,
        S_RD_CAP = 3'd4
    } state_e;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/sram_access_arbiter.sv
// ----------------------------------------------------------------------------
// sram_access_arbiter
//   Shares one asynchronous 16-bit SRAM between the recorder (writes) and the
//   player (reads). Requests are granted round-robin from S_IDLE; every access
//   is grant + two access states + the return to S_IDLE. The highest written
//   address is tracked as a recorded length, and reads at or beyond it return
//   silence without enabling the SRAM outputs.
//
// Ports
//   i_clk, i_rst_n              bit clock, async active-low reset
//   i_wr_req/i_wr_addr/i_wr_data write request (level), o_wr_ack 1-cycle pulse
//   i_rd_req/i_rd_addr          read request (level)
//   o_rd_data, o_rd_valid       read data (held), 1-cycle valid pulse
//   i_clr_len                   clear recorded length
//   o_rec_len                   highest written address + 1
//   o_busy                      high whenever an access is in progress
//   o_SRAM_* / io_SRAM_DQ       SRAM pins (CE/LB/UB tied active)
// ----------------------------------------------------------------------------
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_clr_len,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    state_e            state_r;
    state_e            state_nxt;
    grant_e            last_grant_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rd_ok_r;
    logic [DATA_W-1:0] rd_data_r;
    logic [ADDR_W:0]   rec_len_r;
    logic              grant_wr;
    logic              grant_rd;
    logic              commit;

    // Length after committing a write at addr on top of base (never shrinks).
    function automatic logic [ADDR_W:0] commit_len(input logic [ADDR_W:0]   base,
                                                   input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] end_len;
        end_len = {1'b0, addr} + (ADDR_W+1)'(1);
        return (end_len > base) ? end_len : base;
    endfunction

    // Under contention the side that was not served last wins.
    assign grant_wr = i_wr_req && (!i_rd_req || (last_grant_r == GNT_RD));
    assign grant_rd = i_rd_req && (!i_wr_req || (last_grant_r == GNT_WR));
    assign commit   = (state_r == S_WR_END);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_wr) begin
                    state_nxt = S_WR;
                end else if (grant_rd) begin
                    state_nxt = S_RD;
                end
            end
            S_WR:     state_nxt = S_WR_END;
            S_WR_END: state_nxt = S_IDLE;
            S_RD:     state_nxt = S_RD_CAP;
            S_RD_CAP: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so the strobes cannot glitch.
    always_comb begin
        o_SRAM_WE_N = (state_r != S_WR);
        o_SRAM_OE_N = !((state_r == S_RD) && rd_ok_r);
        o_wr_ack    = (state_r == S_WR_END);
        o_rd_valid  = (state_r == S_RD_CAP);
        o_busy      = (state_r != S_IDLE);
    end

    // Access registers: address/data latched at grant, read data captured as
    // S_RD ends so it is already stable during the S_RD_CAP valid cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_r <= GNT_RD;
            addr_r       <= '0;
            wdata_r      <= '0;
            rd_ok_r      <= 1'b0;
            rd_data_r    <= '0;
        end else begin
            if (state_r == S_IDLE) begin
                if (grant_wr) begin
                    last_grant_r <= GNT_WR;
                    addr_r       <= i_wr_addr;
                    wdata_r      <= i_wr_data;
                end else if (grant_rd) begin
                    last_grant_r <= GNT_RD;
                    addr_r       <= i_rd_addr;
                    rd_ok_r      <= ({1'b0, i_rd_addr} < rec_len_r);
                end
            end
            if (state_r == S_RD) begin
                rd_data_r <= rd_ok_r ? io_SRAM_DQ : '0;
            end
        end
    end

    // Recorded length: a clear takes effect before a same-cycle commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rec_len_r <= '0;
        end else if (i_clr_len) begin
            rec_len_r <= commit ? commit_len('0, addr_r) : '0;
        end else if (commit) begin
            rec_len_r <= commit_len(rec_len_r, addr_r);
        end
    end

    // Data and address are held through S_WR_END so the write closes on WE_N rising.
    assign io_SRAM_DQ  = ((state_r == S_WR) || (state_r == S_WR_END)) ? wdata_r : 'z;
    assign o_SRAM_ADDR = addr_r;
    assign o_rd_data   = rd_data_r;
    assign o_rec_len   = rec_len_r;
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        clr_len;
    logic [20:0] rec_len;
    logic        busy;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

    // Behavioural asynchronous SRAM: reads drive DQ while OE_N is low,
    // writes land on the rising edge of WE_N.
    logic [15:0] sram_mem [0:(1<<20)-1];
    assign sram_dq = (!sram_oe_n) ? sram_mem[sram_addr] : 16'hzzzz;

    initial begin
        for (int i = 0; i < (1 << 20); i++) sram_mem[i] = 16'h0000;
        forever begin
            @(posedge sram_we_n);
            if (rst_n) sram_mem[sram_addr] = sram_dq;
        end
    end

    // Reference model for the randomized phase
    logic [15:0] exp_mem [int];
    logic [20:0] exp_len;
    bit          last_rd;   // 1: the read side was served most recently

    sram_access_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_req    (wr_req),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ack    (wr_ack),
        .i_rd_req    (rd_req),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .i_clr_len   (clr_len),
        .o_rec_len   (rec_len),
        .o_busy      (busy),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (sram_dq),
        .o_SRAM_WE_N (sram_we_n),
        .o_SRAM_OE_N (sram_oe_n),
        .o_SRAM_CE_N (sram_ce_n),
        .o_SRAM_LB_N (sram_lb_n),
        .o_SRAM_UB_N (sram_ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!sram_we_n && !sram_oe_n) overlap++;
    end

    function automatic logic [15:0] model_read(input logic [19:0] a);
        if (!({1'b0, a} < exp_len)) return 16'h0000;
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 16'h0000;
    endfunction

    function automatic void model_write(input logic [19:0] a, input logic [15:0] d, input bit clr);
        logic [20:0] e;
        e = {1'b0, a} + 21'd1;
        exp_mem[int'(a)] = d;
        if (clr) exp_len = e;
        else if (e > exp_len) exp_len = e;
    endfunction

    // Drives one write and/or read request, holding each until its ack/valid,
    // and reports what was observed. Latencies count negedges after the request.
    task automatic run_access(input bit do_wr, input bit do_rd,
                              input logic [19:0] wa, input logic [15:0] wd,
                              input logic [19:0] ra, input bit clr_at_commit,
                              output int wl, output int rl, output logic [15:0] rdat,
                              output int we_cnt, output int oe_cnt,
                              output logic [20:0] len_after, output logic busy_after);
        bit wr_done;
        bit rd_done;
        wl = -1; rl = -1; rdat = 16'h0000; we_cnt = 0; oe_cnt = 0;
        wr_done = !do_wr;
        rd_done = !do_rd;
        @(posedge clk); #1;
        wr_req = do_wr; wr_addr = wa; wr_data = wd;
        rd_req = do_rd; rd_addr = ra;
        for (int k = 1; k <= 14 && !(wr_done && rd_done); k++) begin
            @(negedge clk);
            if (!sram_we_n) we_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (wr_ack) begin
                if (wl < 0) wl = k;
                wr_done = 1'b1;
                if (clr_at_commit) clr_len = 1'b1;
            end
            if (rd_valid) begin
                if (rl < 0) rl = k;
                rdat = rd_data;
                rd_done = 1'b1;
            end
            @(posedge clk); #1;
            if (wr_done) wr_req = 1'b0;
            if (rd_done) rd_req = 1'b0;
            clr_len = 1'b0;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        len_after  = rec_len;
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n got=%b want=1", sram_we_n); end
        total++; if (sram_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", sram_oe_n); end
        total++; if (sram_addr !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
        total++; if (wr_ack !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b want=00", wr_ack, rd_valid); end
        total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        total++; if (rec_len !== 21'h0) begin bad++; $display("FAIL reset_rec_len got=%h want=0", rec_len); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after_release got=%b want=0", busy); end
    endtask

    task automatic test_single_write;
        int wl, rl, we, oe; logic [15:0] rd; logic [20:0] len; logic bz;
        run_access(1, 0, 20'h00010, 16'hBEEF, 20'h0, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (wl !== 3)  begin bad++; $display("FAIL wr_ack_latency got=%0d want=3", wl); end
        total++; if (we !== 1)  begin bad++; $display("FAIL wr_we_low_cycles got=%0d want=1", we); end
        total++; if (oe !== 0)  begin bad++; $display("FAIL wr_oe_low_cycles got=%0d want=0", oe); end
        total++; if (len !== 21'h11) begin bad++; $display("FAIL wr_rec_len got=%h want=11", len); end
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL wr_busy_after got=%b want=0", bz); end
    endtask

    task automatic test_single_read;
        int wl, rl, we, oe; logic [15:0] rd; logic [20:0] len; logic bz;
        run_access(0, 1, 20'h0, 16'h0, 20'h00010, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (rl !== 3) begin bad++; $display("FAIL rd_valid_latency got=%0d want=3", rl); end
        total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h want=beef", rd); end
        total++; if (oe !== 1) begin bad++; $display("FAIL rd_oe_low_cycles got=%0d want=1", oe); end
        total++; if (we !== 0) begin bad++; $display("FAIL rd_we_low_cycles got=%0d want=0", we); end
        @(negedge clk);
        total++; if (rd_data !== 16'hBEEF) begin bad++; $display("FAIL rd_data_held got=%h want=beef", rd_data); end
    endtask

    task automatic test_contention;
        string got_order;
        int acks, vals, bad_data;
        got_order = "";
        acks = 0; vals = 0; bad_data = 0;
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = 20'h00008; wr_data = 16'h1234;
        rd_req = 1'b1; rd_addr = 20'h00010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (wr_ack) begin acks++; got_order = {got_order, "W"}; end
            if (rd_valid) begin
                vals++; got_order = {got_order, "R"};
                if (rd_data !== 16'hBEEF) bad_data++;
            end
        end
        @(posedge clk); #1;
        wr_req = 1'b0; rd_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_ack) acks++;
            if (rd_valid) vals++;
        end
        total++; if (got_order != "WRWR") begin bad++; $display("FAIL contention_order got=%s want=WRWR", got_order); end
        total++; if (acks !== 2) begin bad++; $display("FAIL contention_acks got=%0d want=2", acks); end
        total++; if (vals !== 2) begin bad++; $display("FAIL contention_valids got=%0d want=2", vals); end
        total++; if (bad_data !== 0) begin bad++; $display("FAIL contention_rd_data got=%0d_bad want=0_bad", bad_data); end
        total++; if (rec_len !== 21'h11) begin bad++; $display("FAIL contention_rec_len got=%h want=11", rec_len); end
    endtask

    task automatic test_out_of_range;
        int wl, rl, we, oe; logic [15:0] rd; logic [20:0] len; logic bz;
        run_access(0, 1, 20'h0, 16'h0, 20'h00020, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (rl !== 3) begin bad++; $display("FAIL oor_latency got=%0d want=3", rl); end
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL oor_rd_data got=%h want=0000", rd); end
        total++; if (oe !== 0) begin bad++; $display("FAIL oor_oe_low_cycles got=%0d want=0", oe); end
    endtask

    task automatic test_rec_len;
        int wl, rl, we, oe; logic [15:0] rd; logic [20:0] len; logic bz;
        run_access(1, 0, 20'h00005, 16'h5555, 20'h0, 1, wl, rl, rd, we, oe, len, bz);
        total++; if (len !== 21'h06) begin bad++; $display("FAIL clr_with_commit got=%h want=06", len); end
        run_access(1, 0, 20'hFFFFF, 16'hA5A5, 20'h0, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (len !== 21'h100000) begin bad++; $display("FAIL max_addr_len got=%h want=100000", len); end
        run_access(0, 1, 20'h0, 16'h0, 20'hFFFFF, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (rd !== 16'hA5A5) begin bad++; $display("FAIL max_addr_read got=%h want=a5a5", rd); end
    endtask

    task automatic test_random;
        int wl, rl, we, oe; logic [15:0] rd; logic [20:0] len; logic bz;
        bit do_wr, do_rd, clr, wr_first;
        logic [19:0] wa, ra;
        logic [15:0] wd, exp_rd;
        int exp_wl, exp_rl, exp_oe, op;
        @(posedge clk); #1; clr_len = 1'b1;
        @(posedge clk); #1; clr_len = 1'b0;
        @(negedge clk);
        exp_len = '0;
        total++; if (rec_len !== 21'h0) begin bad++; $display("FAIL rand_clr got=%h want=0", rec_len); end
        for (int it = 0; it < 40; it++) begin
            op = (it == 0) ? 0 : int'($urandom_range(0, 2));
            do_wr = (op != 1);
            do_rd = (op != 0);
            wa = 20'h00100 + 20'($urandom_range(0, 47));
            ra = 20'h00100 + 20'($urandom_range(0, 47));
            wd = 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            wr_first = do_wr && (!do_rd || last_rd);
            exp_rd = 16'h0; exp_oe = 0;
            if (do_wr && wr_first) model_write(wa, wd, clr);
            if (do_rd) begin
                exp_oe = ({1'b0, ra} < exp_len) ? 1 : 0;
                exp_rd = model_read(ra);
            end
            if (do_wr && !wr_first) model_write(wa, wd, clr);
            exp_wl = do_wr ? (wr_first ? 3 : 6) : -1;
            exp_rl = do_rd ? ((do_wr && wr_first) ? 6 : 3) : -1;
            last_rd = (do_wr && do_rd) ? wr_first : do_rd;
            run_access(do_wr, do_rd, wa, wd, ra, clr, wl, rl, rd, we, oe, len, bz);
            total++; if (wl !== exp_wl) begin bad++; $display("FAIL rand%0d_wr_latency got=%0d want=%0d", it, wl, exp_wl); end
            total++; if (rl !== exp_rl) begin bad++; $display("FAIL rand%0d_rd_latency got=%0d want=%0d", it, rl, exp_rl); end
            if (do_rd) begin
                total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand%0d_rd_data got=%h want=%h", it, rd, exp_rd); end
            end
            total++; if (oe !== exp_oe) begin bad++; $display("FAIL rand%0d_oe_cycles got=%0d want=%0d", it, oe, exp_oe); end
            total++; if (we !== (do_wr ? 1 : 0)) begin bad++; $display("FAIL rand%0d_we_cycles got=%0d want=%0d", it, we, do_wr ? 1 : 0); end
            total++; if (len !== exp_len) begin bad++; $display("FAIL rand%0d_rec_len got=%h want=%h", it, len, exp_len); end
            total++; if (bz !== 1'b0) begin bad++; $display("FAIL rand%0d_busy got=%b want=0", it, bz); end
        end
    endtask

    task automatic test_reset_mid_access;
        int wl, rl, we, oe; logic [15:0] rd; logic [20:0] len; logic bz;
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = 20'h00030; wr_data = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        total++; if (sram_we_n !== 1'b0) begin bad++; $display("FAIL midrst_in_write got=%b want=0", sram_we_n); end
        rst_n = 1'b0;
        #1;
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL midrst_we_n got=%b want=1", sram_we_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b want=0", wr_ack); end
        total++; if (rec_len !== 21'h0) begin bad++; $display("FAIL midrst_rec_len got=%h want=0", rec_len); end
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack_late got=%b want=0", wr_ack); end
        rst_n = 1'b1;
        run_access(1, 0, 20'h00031, 16'h7777, 20'h0, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (wl !== 3) begin bad++; $display("FAIL postrst_wr_latency got=%0d want=3", wl); end
        total++; if (len !== 21'h32) begin bad++; $display("FAIL postrst_rec_len got=%h want=32", len); end
        run_access(0, 1, 20'h0, 16'h0, 20'h00030, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (rd !== 16'h0000) begin bad++; $display("FAIL aborted_write_visible got=%h want=0000", rd); end
        run_access(0, 1, 20'h0, 16'h0, 20'h00031, 0, wl, rl, rd, we, oe, len, bz);
        total++; if (rd !== 16'h7777) begin bad++; $display("FAIL postrst_read got=%h want=7777", rd); end
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_len = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        exp_len = '0; last_rd = 1'b1;
        test_reset;
        test_single_write;
        test_single_read;
        test_contention;
        test_out_of_range;
        test_rec_len;
        test_random;
        test_reset_mid_access;
        total++; if (overlap !== 0) begin bad++; $display("FAIL we_oe_overlap got=%0d want=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
